// File: rtl/sdram2m_responder.sv
`timescale 1ns/1ps
// sdram2m_responder: RAM-backed stand-in for the SDRAM controller's req/ack burst port,
// with settable read latency and emulated init and auto-refresh stalls.
module sdram2m_responder #(
    parameter int ADDR_W      = 8,
    parameter int CAS_LAT     = 3,
    parameter int INIT_CYCLES = 200,
    parameter int REF_PERIOD  = 780,
    parameter int REF_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_wr_req,
    output logic        sdram_wr_ack,
    input  logic [19:0] sdram_wr_addr,
    input  logic [9:0]  sdram_wr_burst,
    input  logic [15:0] sdram_din,
    input  logic        sdram_rd_req,
    output logic        sdram_rd_ack,
    input  logic [19:0] sdram_rd_addr,
    input  logic [9:0]  sdram_rd_burst,
    output logic [15:0] sdram_dout,
    input  logic        block_auto_refresh,
    output logic        sdram_init_done
);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_REFRESH  = 3'd2;
    localparam logic [2:0] S_WR_LAT   = 3'd3;
    localparam logic [2:0] S_WR_BURST = 3'd4;
    localparam logic [2:0] S_WR_TAIL  = 3'd5;
    localparam logic [2:0] S_RD_LAT   = 3'd6;
    localparam logic [2:0] S_RD_BURST = 3'd7;

    localparam int INIT_W   = $clog2(INIT_CYCLES + 1);
    localparam int REF_W    = $clog2(REF_PERIOD + 1);
    localparam int STALL_W  = $clog2(REF_CYCLES + 1);
    localparam int LAT_W    = $clog2(CAS_LAT + 1);
    localparam int LAT_LAST = (CAS_LAT >= 2) ? CAS_LAT - 2 : 0;
    localparam int REF_LAST = (REF_CYCLES >= 2) ? REF_CYCLES - 2 : 0;

    logic [2:0]         state;
    logic [INIT_W-1:0]  init_cnt;
    logic [REF_W-1:0]   ref_cnt;
    logic               ref_pending;
    logic [STALL_W-1:0] stall_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [9:0]         burst_len;
    logic [9:0]         word_cnt;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic               wr_we_d;
    logic               wr_arm;
    logic               rd_arm;
    logic               ref_take;
    logic               wr_accept;
    logic               rd_accept;
    logic               lat_done;
    logic               unused_addr_bits;
    logic [15:0]        mem [0:(2**ADDR_W)-1];

    assign unused_addr_bits = ^{sdram_wr_addr[19:ADDR_W], sdram_rd_addr[19:ADDR_W]};

    always_comb begin
        ref_take  = (state == S_IDLE) && ref_pending && !block_auto_refresh;
        wr_accept = (state == S_IDLE) && !ref_take && wr_arm && sdram_wr_req;
        rd_accept = (state == S_IDLE) && !ref_take && !wr_accept && rd_arm && sdram_rd_req;
        lat_done  = (lat_cnt == LAT_W'(LAT_LAST));
    end

    // An arm re-opens only after its request has been seen low, so a held req cannot retrigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_arm <= 1'b1;
            rd_arm <= 1'b1;
        end else begin
            if (!sdram_wr_req)
                wr_arm <= 1'b1;
            else if (wr_accept)
                wr_arm <= 1'b0;
            if (!sdram_rd_req)
                rd_arm <= 1'b1;
            else if (rd_accept)
                rd_arm <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else if (sdram_init_done) begin
            if (ref_cnt == REF_W'(REF_PERIOD - 1)) begin
                ref_cnt     <= '0;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
                if (ref_take)
                    ref_pending <= 1'b0;
            end
        end
    end

    // Write data arrives one cycle after its ack, so the address is delayed to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_we_d   <= 1'b0;
            wr_addr_d <= '0;
        end else begin
            wr_we_d   <= sdram_wr_ack;
            wr_addr_d <= cur_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_we_d)
            mem[wr_addr_d] <= sdram_din;
    end

    // The refresh slot includes the IDLE cycle that follows it, so a waiting request sees REF_CYCLES extra cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_INIT;
            init_cnt        <= '0;
            sdram_init_done <= 1'b0;
            stall_cnt       <= '0;
            lat_cnt         <= '0;
            burst_len       <= '0;
            word_cnt        <= '0;
            cur_addr        <= '0;
            sdram_wr_ack    <= 1'b0;
            sdram_rd_ack    <= 1'b0;
            sdram_dout      <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        sdram_init_done <= 1'b1;
                        state           <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (ref_take) begin
                        state     <= S_REFRESH;
                        stall_cnt <= '0;
                    end else if (wr_accept) begin
                        cur_addr  <= sdram_wr_addr[ADDR_W-1:0];
                        burst_len <= (sdram_wr_burst == 10'd0) ? 10'd1 : sdram_wr_burst;
                        word_cnt  <= '0;
                        lat_cnt   <= '0;
                        if (CAS_LAT == 1) begin
                            state        <= S_WR_BURST;
                            sdram_wr_ack <= 1'b1;
                        end else begin
                            state <= S_WR_LAT;
                        end
                    end else if (rd_accept) begin
                        burst_len <= (sdram_rd_burst == 10'd0) ? 10'd1 : sdram_rd_burst;
                        word_cnt  <= '0;
                        lat_cnt   <= '0;
                        if (CAS_LAT == 1) begin
                            state        <= S_RD_BURST;
                            sdram_rd_ack <= 1'b1;
                            sdram_dout   <= mem[sdram_rd_addr[ADDR_W-1:0]];
                            cur_addr     <= sdram_rd_addr[ADDR_W-1:0] + 1'b1;
                        end else begin
                            state    <= S_RD_LAT;
                            cur_addr <= sdram_rd_addr[ADDR_W-1:0];
                        end
                    end
                end
                S_REFRESH: begin
                    if (stall_cnt == STALL_W'(REF_LAST))
                        state <= S_IDLE;
                    else
                        stall_cnt <= stall_cnt + 1'b1;
                end
                S_WR_LAT: begin
                    if (lat_done) begin
                        state        <= S_WR_BURST;
                        sdram_wr_ack <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_WR_BURST: begin
                    cur_addr <= cur_addr + 1'b1;
                    if (word_cnt == burst_len - 10'd1) begin
                        sdram_wr_ack <= 1'b0;
                        state        <= S_WR_TAIL;
                    end else begin
                        word_cnt <= word_cnt + 10'd1;
                    end
                end
                S_WR_TAIL: begin
                    state <= S_IDLE;
                end
                S_RD_LAT: begin
                    if (lat_done) begin
                        state        <= S_RD_BURST;
                        sdram_rd_ack <= 1'b1;
                        sdram_dout   <= mem[cur_addr];
                        cur_addr     <= cur_addr + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_RD_BURST: begin
                    if (word_cnt == burst_len - 10'd1) begin
                        sdram_rd_ack <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        word_cnt   <= word_cnt + 10'd1;
                        sdram_dout <= mem[cur_addr];
                        cur_addr   <= cur_addr + 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram2m_responder.sv
`timescale 1ns/1ps
// tb_sdram2m_responder: directed vector table, multi-cycle corner sequences and random bursts
// checked against an address-wrapped memory model and cycle-count expectations.
module tb_sdram2m_responder;

    localparam int CAS_LAT     = 3;
    localparam int INIT_CYCLES = 200;
    localparam int REF_PERIOD  = 780;
    localparam int REF_CYCLES  = 8;
    localparam int NVEC        = 10;

    typedef struct {
        bit          is_wr;
        logic [19:0] addr;
        int          burst;
        logic [15:0] data_base;
        int          hold;
        int          exp_acks;
        int          exp_lat;
        string       tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_wr_req = 1'b0;
    logic        sdram_wr_ack;
    logic [19:0] sdram_wr_addr = '0;
    logic [9:0]  sdram_wr_burst = '0;
    logic [15:0] sdram_din = '0;
    logic        sdram_rd_req = 1'b0;
    logic        sdram_rd_ack;
    logic [19:0] sdram_rd_addr = '0;
    logic [9:0]  sdram_rd_burst = '0;
    logic [15:0] sdram_dout;
    logic        block_auto_refresh = 1'b0;
    logic        sdram_init_done;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          rst_cyc = 0;
    int          first_seen;
    logic [15:0] mem_model [256];
    bit          mem_valid [256];
    logic [15:0] words [1024];
    vec_t        vecs [NVEC];

    sdram2m_responder #(
        .ADDR_W(8), .CAS_LAT(CAS_LAT), .INIT_CYCLES(INIT_CYCLES),
        .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst), .sdram_din(sdram_din),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst), .sdram_dout(sdram_dout),
        .block_auto_refresh(block_auto_refresh), .sdram_init_done(sdram_init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Initiator side of a write: din is registered on each ack, the model follows the wrapped address.
    task automatic doWrite(input logic [19:0] a, input int n, input int hold, input int exp_acks,
                           input int exp_lat, input string tag, output int first_ack);
        int acks = 0;
        int k = 0;
        int idx;
        int extra = 0;
        int t0;
        bit prev = 1'b0;
        bit done = 1'b0;
        first_ack = -1;
        sdram_wr_addr  = a;
        sdram_wr_burst = 10'(n);
        sdram_wr_req   = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (prev) begin
                sdram_din = words[k];
                idx = (int'(a[7:0]) + k) % 256;
                mem_model[idx] = words[k];
                mem_valid[idx] = 1'b1;
                k++;
            end
            prev = sdram_wr_ack;
            if (sdram_wr_ack) begin
                acks++;
                if (first_ack < 0) first_ack = cyc;
            end else if (acks > 0) begin
                done = 1'b1;
            end
        end
        checkOutput({tag, " burst completed"}, 32'(done), 32'd1);
        checkOutput({tag, " wr_ack count"}, acks, exp_acks);
        if (exp_lat >= 0) checkOutput({tag, " wr latency"}, first_ack - t0, exp_lat);
        for (int i = 0; i < hold; i++) begin
            step();
            if (sdram_wr_ack) extra++;
        end
        if (hold > 0) checkOutput({tag, " no retrigger while held"}, extra, 0);
        sdram_wr_req = 1'b0;
        step();
    endtask

    task automatic doRead(input logic [19:0] a, input int n, input int hold, input int exp_acks,
                          input int exp_lat, input string tag);
        int acks = 0;
        int first = -1;
        int idx = 0;
        int extra = 0;
        int t0;
        bit done = 1'b0;
        sdram_rd_addr  = a;
        sdram_rd_burst = 10'(n);
        sdram_rd_req   = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (sdram_rd_ack) begin
                idx = (int'(a[7:0]) + acks) % 256;
                if (mem_valid[idx])
                    checkOutput({tag, " rd data"}, 32'(sdram_dout), 32'(mem_model[idx]));
                if (first < 0) first = cyc;
                acks++;
            end else if (acks > 0) begin
                done = 1'b1;
            end
        end
        checkOutput({tag, " burst completed"}, 32'(done), 32'd1);
        checkOutput({tag, " rd_ack count"}, acks, exp_acks);
        if (exp_lat >= 0) checkOutput({tag, " rd latency"}, first - t0, exp_lat);
        if (done && mem_valid[idx])
            checkOutput({tag, " dout holds last word"}, 32'(sdram_dout), 32'(mem_model[idx]));
        for (int i = 0; i < hold; i++) begin
            step();
            if (sdram_rd_ack) extra++;
        end
        if (hold > 0) checkOutput({tag, " no retrigger while held"}, extra, 0);
        sdram_rd_req = 1'b0;
        step();
    endtask

    task automatic applyStimulus(input vec_t v);
        int f;
        for (int k = 0; k < 1024; k++) words[k] = v.data_base + 16'(k);
        if (v.is_wr)
            doWrite(v.addr, v.burst, v.hold, v.exp_acks, v.exp_lat, v.tag, f);
        else
            doRead(v.addr, v.burst, v.hold, v.exp_acks, v.exp_lat, v.tag);
    endtask

    task automatic testPowerUp();
        int early = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) step();
        checkOutput("reset wr_ack", 32'(sdram_wr_ack), 32'd0);
        checkOutput("reset rd_ack", 32'(sdram_rd_ack), 32'd0);
        checkOutput("reset dout", 32'(sdram_dout), 32'd0);
        checkOutput("reset init_done", 32'(sdram_init_done), 32'd0);
        rst_n = 1'b1;
        rst_cyc = cyc;
        repeat (5) step();
        sdram_wr_addr  = 20'h00000;
        sdram_wr_burst = 10'd2;
        sdram_wr_req   = 1'b1;
        while (cyc - rst_cyc < INIT_CYCLES - 1) begin
            step();
            if (sdram_wr_ack) early++;
        end
        checkOutput("init_done low before init", 32'(sdram_init_done), 32'd0);
        step();
        if (sdram_wr_ack) early++;
        checkOutput("init_done rises at init end", 32'(sdram_init_done), 32'd1);
        checkOutput("no wr_ack during init", early, 0);
        words[0] = 16'h1111;
        words[1] = 16'h1112;
        doWrite(20'h00000, 2, 0, 2, -1, "t1 held write", first_seen);
        checkOutput("t1 first wr_ack cycle", first_seen - rst_cyc, INIT_CYCLES + CAS_LAT);
    endtask

    task automatic testSimultaneous();
        int wr_acks = 0;
        int rd_acks = 0;
        int first_wr = -1;
        int last_wr = -1;
        int first_rd = -1;
        int k = 0;
        int idx;
        int t0;
        bit wprev = 1'b0;
        bit rd_done = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = 16'h4000 + 16'(i);
        sdram_wr_addr  = 20'h00040;
        sdram_wr_burst = 10'd4;
        sdram_rd_addr  = 20'h00040;
        sdram_rd_burst = 10'd4;
        sdram_wr_req   = 1'b1;
        sdram_rd_req   = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 200 && !rd_done; i++) begin
            step();
            if (wprev) begin
                sdram_din = words[k];
                idx = (16'h40 + k) % 256;
                mem_model[idx] = words[k];
                mem_valid[idx] = 1'b1;
                k++;
            end
            wprev = sdram_wr_ack;
            if (sdram_wr_ack) begin
                wr_acks++;
                last_wr = cyc;
                if (first_wr < 0) first_wr = cyc;
            end else if (wr_acks > 0) begin
                sdram_wr_req = 1'b0;
            end
            if (sdram_rd_ack) begin
                checkOutput("t4 rd data", 32'(sdram_dout), 32'(16'h4000 + 16'(rd_acks)));
                if (first_rd < 0) first_rd = cyc;
                rd_acks++;
            end else if (rd_acks > 0) begin
                rd_done = 1'b1;
            end
        end
        sdram_wr_req = 1'b0;
        sdram_rd_req = 1'b0;
        step();
        checkOutput("t4 read completed", 32'(rd_done), 32'd1);
        checkOutput("t4 wr_ack count", wr_acks, 4);
        checkOutput("t4 rd_ack count", rd_acks, 4);
        checkOutput("t4 write latency", first_wr - t0, CAS_LAT);
        checkOutput("t4 read after write", 32'(first_rd > last_wr), 32'd1);
    endtask

    task automatic testRandom();
        int f;
        bit is_wr;
        logic [19:0] a;
        int n;
        block_auto_refresh = 1'b1;
        for (int k = 0; k < 256; k++) words[k] = 16'($urandom);
        doWrite(20'($urandom), 256, 0, 256, CAS_LAT, "rnd fill", f);
        for (int t = 0; t < 40; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            a     = 20'($urandom);
            n     = $urandom_range(0, 20);
            for (int k = 0; k < 21; k++) words[k] = 16'($urandom);
            if (is_wr)
                doWrite(a, n, $urandom_range(0, 2), (n == 0) ? 1 : n, CAS_LAT, "rnd write", f);
            else
                doRead(a, n, $urandom_range(0, 2), (n == 0) ? 1 : n, CAS_LAT, "rnd read");
        end
    endtask

    // Refresh periods expire at fixed offsets after init_done; the bench waits to a known phase.
    task automatic waitPhase(input int phase, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 2 * REF_PERIOD && !found; i++) begin
            step();
            if ((cyc - rst_cyc) > INIT_CYCLES &&
                ((cyc - rst_cyc - INIT_CYCLES) % REF_PERIOD) == phase)
                found = 1'b1;
        end
        checkOutput({tag, " phase reached"}, 32'(found), 32'd1);
    endtask

    task automatic testRefreshBlock();
        block_auto_refresh = 1'b1;
        waitPhase(50, "t5 first period");
        waitPhase(50, "t5 second period");
        doRead(20'h00010, 4, 0, 4, CAS_LAT, "t5 blocked read");
        block_auto_refresh = 1'b0;
        doRead(20'h00010, 4, 0, 4, CAS_LAT + REF_CYCLES, "t5 stalled read");
        doRead(20'h00010, 4, 0, 4, CAS_LAT, "t5 no second stall");
    endtask

    task automatic testResetMidBurst();
        int acks = 0;
        bit ok = 1'b0;
        sdram_rd_addr  = 20'h00010;
        sdram_rd_burst = 10'd16;
        sdram_rd_req   = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (sdram_rd_ack) acks++;
            if (acks == 5) ok = 1'b1;
        end
        checkOutput("reset-mid-burst acks seen", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset-mid-burst rd_ack", 32'(sdram_rd_ack), 32'd0);
        checkOutput("reset-mid-burst init_done", 32'(sdram_init_done), 32'd0);
        checkOutput("reset-mid-burst dout", 32'(sdram_dout), 32'd0);
        sdram_rd_req = 1'b0;
        step();
        rst_n = 1'b1;
        rst_cyc = cyc;
        while (cyc - rst_cyc < INIT_CYCLES) step();
        checkOutput("re-init done", 32'(sdram_init_done), 32'd1);
        doRead(20'h000FE, 4, 0, 4, CAS_LAT, "RAM kept across reset");
    endtask

    initial begin
        vecs[0] = '{1'b1, 20'h00010, 16, 16'hA000, 0, 16, CAS_LAT, "t2 write16"};
        vecs[1] = '{1'b0, 20'h00010, 4,  16'h0000, 0, 4,  CAS_LAT, "t2 read4"};
        vecs[2] = '{1'b1, 20'h000FE, 4,  16'h3000, 0, 4,  CAS_LAT, "t3 prefill"};
        vecs[3] = '{1'b0, 20'h000FE, 4,  16'h0000, 0, 4,  CAS_LAT, "t3 wrap read"};
        vecs[4] = '{1'b0, 20'h5A0FF, 2,  16'h0000, 0, 2,  CAS_LAT, "alias read"};
        vecs[5] = '{1'b1, 20'h00080, 0,  16'h5500, 0, 1,  CAS_LAT, "burst0 write"};
        vecs[6] = '{1'b0, 20'h00080, 0,  16'h0000, 0, 1,  CAS_LAT, "burst0 read"};
        vecs[7] = '{1'b1, 20'h00030, 5,  16'h6000, 3, 5,  CAS_LAT, "t6 held req"};
        vecs[8] = '{1'b1, 20'h00030, 5,  16'h6100, 0, 5,  CAS_LAT, "t6 rearmed"};
        vecs[9] = '{1'b0, 20'h00030, 5,  16'h0000, 0, 5,  CAS_LAT, "t6 readback"};

        testPowerUp();
        for (int v = 0; v < NVEC; v++) applyStimulus(vecs[v]);
        testSimultaneous();
        testRandom();
        testRefreshBlock();
        testResetMidBurst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
